// File: rtl/buffer_pkg.sv
// Shared constants and state encoding for the sample buffer and its read sequencer.
package buffer_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 16;
  localparam int BUF_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PRESENT
  } reader_state_e;

endpackage

// File: rtl/buffer_reader.sv
// Read-side sequencer: walks a (base, length) window of the sample buffer and
// presents each sample on a valid/ready stream, one-shot or looped.
module buffer_reader #(
  parameter int DATA_W       = buffer_pkg::DATA_W,
  parameter int ADDR_W       = buffer_pkg::ADDR_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] buf_address,
  output logic              buf_oe,
  input  logic [DATA_W-1:0] buf_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);
  import buffer_pkg::*;

  localparam int LEN_W  = ADDR_W + 1;
  localparam int WAIT_W = 3;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  reader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              loop_q, loop_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_sample;

  assign last_sample = (count_q == (len_q - 1'b1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    base_d    = base_q;
    count_d   = count_q;
    len_d     = len_q;
    loop_d    = loop_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    oe_d      = oe_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    done_d    = 1'b0;

    // stop outranks both a pending start and a same-cycle handshake
    if (stop && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop && (length != '0)) begin
            base_d  = base_addr;
            len_d   = (length > MAX_LEN) ? MAX_LEN : length;
            loop_d  = loop;
            ptr_d   = base_addr;
            count_d = '0;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          addr_d  = ptr_q;
          oe_d    = 1'b1;
          wait_d  = WAIT_W'(READ_LATENCY);
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == '0) begin
            m_data_d  = buf_data;
            m_valid_d = 1'b1;
            m_last_d  = last_sample;
            oe_d      = 1'b0;
            state_d   = ST_PRESENT;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end
        ST_PRESENT: begin
          if (m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            if (!last_sample) begin
              count_d = count_q + 1'b1;
              ptr_d   = ptr_q + 1'b1;
              state_d = ST_ISSUE;
            end else if (loop_q) begin
              count_d = '0;
              ptr_d   = base_q;
              state_d = ST_ISSUE;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      base_q    <= '0;
      count_q   <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      wait_q    <= '0;
      addr_q    <= '0;
      oe_q      <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      base_q    <= base_d;
      count_q   <= count_d;
      len_q     <= len_d;
      loop_q    <= loop_d;
      wait_q    <= wait_d;
      addr_q    <= addr_d;
      oe_q      <= oe_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign buf_address = addr_q;
  assign buf_oe      = oe_q;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_buffer_reader.sv
// Testbench for buffer_reader: two instances (read latency 1 and 3) against a
// behavioural buffer memory and a window-walking reference model.
module tb_buffer_reader;

  localparam int RL_A = 1;
  localparam int RL_B = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  length = '0;
  logic        m_ready = 1'b0;

  logic [3:0]  buf_address_a, buf_address_b;
  logic        buf_oe_a, buf_oe_b;
  logic [15:0] buf_data_a = '0;
  logic [15:0] buf_data_b;
  logic [15:0] m_data_a, m_data_b;
  logic        m_valid_a, m_valid_b;
  logic        m_last_a, m_last_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;

  int checks = 0;
  int failures = 0;

  buffer_reader #(.DATA_W(16), .ADDR_W(4), .READ_LATENCY(RL_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop_en),
    .base_addr(base_addr), .length(length),
    .buf_address(buf_address_a), .buf_oe(buf_oe_a), .buf_data(buf_data_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_last(m_last_a),
    .busy(busy_a), .done(done_a)
  );

  buffer_reader #(.DATA_W(16), .ADDR_W(4), .READ_LATENCY(RL_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop_en),
    .base_addr(base_addr), .length(length),
    .buf_address(buf_address_b), .buf_oe(buf_oe_b), .buf_data(buf_data_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_last(m_last_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Buffer memory model: registered read whose output lags the address by the
  // instance's read latency.
  logic [15:0] mem [16];
  logic [15:0] pipe_b [3];

  always @(posedge clk) begin
    if (buf_oe_a) buf_data_a <= mem[buf_address_a];
  end

  always @(posedge clk) begin
    if (buf_oe_b) pipe_b[0] <= mem[buf_address_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign buf_data_b = pipe_b[2];

  // Consumer ready: 0 = always ready, 1 = random, 2 = held off.
  int ready_mode = 0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor on the falling edge: records handshakes that the coming rising
  // edge will complete, every new buffer read address, and done pulses.
  logic [15:0] hs_data_q [$];
  logic        hs_last_q [$];
  logic [3:0]  addr_q [$];
  int          done_cnt = 0;
  int          done_busy_bad = 0;
  logic        oe_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid_a && m_ready && !stop) begin
        hs_data_q.push_back(m_data_a);
        hs_last_q.push_back(m_last_a);
      end
      if (buf_oe_a && !oe_prev) addr_q.push_back(buf_address_a);
      if (done_a) begin
        done_cnt++;
        if (busy_a) done_busy_bad++;
      end
    end
    oe_prev = buf_oe_a;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic [4:0] len, input logic lp);
    tick();
    base_addr = b;
    length    = len;
    loop_en   = lp;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic clearMonitor();
    hs_data_q.delete();
    hs_last_q.delete();
    addr_q.delete();
    done_cnt      = 0;
    done_busy_bad = 0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_a || busy_b) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) checkOutput({tag, "_idle_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic checkOutputsZero(input string tag);
    checkOutput({tag, "_buf_address"}, 32'(buf_address_a), 0);
    checkOutput({tag, "_buf_oe"},      32'(buf_oe_a), 0);
    checkOutput({tag, "_m_data"},      32'(m_data_a), 0);
    checkOutput({tag, "_m_valid"},     32'(m_valid_a), 0);
    checkOutput({tag, "_m_last"},      32'(m_last_a), 0);
    checkOutput({tag, "_busy"},        32'(busy_a), 0);
    checkOutput({tag, "_done"},        32'(done_a), 0);
  endtask

  // Reference: a one-shot pass reads entries base, base+1, ... modulo 16,
  // min(len,16) of them, with last flagged on the final one and one done.
  task automatic checkPass(input string tag, input int b, input int len);
    int eff;
    int a;
    eff = (len > 16) ? 16 : len;
    checkOutput({tag, "_count"}, 32'(hs_data_q.size()), 32'(eff));
    checkOutput({tag, "_reads"}, 32'(addr_q.size()), 32'(eff));
    for (int i = 0; i < eff; i++) begin
      a = (b + i) % 16;
      if (i < hs_data_q.size()) begin
        checkOutput($sformatf("%s_data%0d", tag, i), 32'(hs_data_q[i]), 32'(mem[a]));
        checkOutput($sformatf("%s_last%0d", tag, i), 32'(hs_last_q[i]), 32'(i == eff - 1));
      end
      if (i < addr_q.size())
        checkOutput($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(a));
    end
    checkOutput({tag, "_done_cnt"}, 32'(done_cnt), 1);
    checkOutput({tag, "_busy_at_done"}, 32'(done_busy_bad), 0);
  endtask

  initial begin
    int lat_a;
    int lat_b;
    int n;
    int stall_bad;
    int rb;
    int rl;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 3; i++) pipe_b[i] = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutputsZero("reset");
    rst_n = 1'b1;

    // Basic one-shot pass and first-sample latency for both read latencies
    mem[0] = 16'd123;
    mem[1] = 16'd234;
    mem[2] = 16'd345;
    clearMonitor();
    ready_mode = 0;
    tick();
    base_addr = 4'd0;
    length    = 5'd3;
    loop_en   = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat_a = -1;
    lat_b = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (m_valid_a && lat_a < 0) lat_a = k - 1;
      if (m_valid_b && lat_b < 0) lat_b = k - 1;
      if (lat_a >= 0 && lat_b >= 0) break;
    end
    checkOutput("latency_rl1", 32'(lat_a), 32'(RL_A + 2));
    checkOutput("latency_rl3", 32'(lat_b), 32'(RL_B + 2));
    waitIdle("basic");
    checkPass("basic", 0, 3);

    // Address wrap from entry 15 back to 0
    mem[14] = 16'h0E0E;
    mem[15] = 16'h0F0F;
    mem[0]  = 16'h1111;
    clearMonitor();
    applyStimulus(4'd14, 5'd3, 1'b0);
    waitIdle("wrap");
    checkPass("wrap", 14, 3);

    // Back-pressure: consumer holds off for 7 cycles after the first valid
    mem[0] = 16'd123;
    clearMonitor();
    ready_mode = 2;
    applyStimulus(4'd0, 5'd2, 1'b0);
    n = 0;
    while (!m_valid_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_first_valid", 32'(m_valid_a), 1);
    stall_bad = 0;
    repeat (7) begin
      @(negedge clk);
      if (m_data_a !== 16'd123 || !m_valid_a || buf_oe_a) stall_bad++;
    end
    checkOutput("bp_stall_stable", 32'(stall_bad), 0);
    checkOutput("bp_held_data", 32'(m_data_a), 32'd123);
    ready_mode = 0;
    waitIdle("bp");
    checkPass("bp", 0, 2);

    // Looped playback, aborted by stop during the fifth sample
    clearMonitor();
    ready_mode = 0;
    applyStimulus(4'd0, 5'd2, 1'b1);
    n = 0;
    while (hs_data_q.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ready_mode = 2;
    n = 0;
    @(negedge clk);
    while (!m_valid_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("loop5_valid", 32'(m_valid_a), 1);
    checkOutput("loop5_data", 32'(m_data_a), 32'd123);
    checkOutput("loop5_last", 32'(m_last_a), 0);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    checkOutput("stop_valid", 32'(m_valid_a), 0);
    checkOutput("stop_busy", 32'(busy_a), 0);
    checkOutput("stop_oe", 32'(buf_oe_a), 0);
    checkOutput("stop_done_cnt", 32'(done_cnt), 0);
    checkOutput("loop_count", 32'(hs_data_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_data_q.size()) begin
        checkOutput($sformatf("loop_data%0d", i), 32'(hs_data_q[i]), 32'(mem[i % 2]));
        checkOutput($sformatf("loop_last%0d", i), 32'(hs_last_q[i]), 32'(i % 2));
      end
    end
    ready_mode = 0;
    waitIdle("stop");

    // Zero-length start is ignored
    clearMonitor();
    applyStimulus(4'd0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("len0_busy", 32'(busy_a), 0);
    checkOutput("len0_done", 32'(done_cnt), 0);

    // A second start while busy changes nothing
    clearMonitor();
    applyStimulus(4'd0, 5'd3, 1'b0);
    repeat (2) tick();
    base_addr = 4'd5;
    length    = 5'd1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    waitIdle("busy_start");
    checkPass("busy_start", 0, 3);

    // Asynchronous reset while a read is outstanding
    clearMonitor();
    applyStimulus(4'd0, 5'd3, 1'b0);
    n = 0;
    while (!buf_oe_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_mid_oe_before", 32'(buf_oe_a), 1);
    rst_n = 1'b0;
    #1;
    checkOutputsZero("rst_mid");
    tick();
    rst_n = 1'b1;

    // Randomized one-shot passes with random consumer back-pressure
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      rb = $urandom_range(0, 15);
      rl = $urandom_range(1, 20);
      ready_mode = 1;
      clearMonitor();
      applyStimulus(4'(rb), 5'(rl), 1'b0);
      waitIdle($sformatf("rand%0d", t));
      checkPass($sformatf("rand%0d", t), rb, rl);
    end
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
